// File: rtl/lc3b_types.sv
// ---------------------------------------------------------------------------
// lc3b_types: shared LC-3b word type, fetch FSM states and small helpers
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DELIVER = 2'd2,
    FLUSH   = 2'd3
  } lc3b_fetch_state;

  localparam lc3b_word WORD_INC = 16'd2;

  // Instructions are word aligned, so the low address bit is always cleared.
  function automatic lc3b_word word_align(input lc3b_word w);
    return {w[15:1], 1'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_pc_register.sv
// ---------------------------------------------------------------------------
// pc_register: 16-bit register with load enable, sync active-low reset
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_register
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] d,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit: LC-3b instruction fetch (PC, memory handshake, IR load strobe)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_req,
  input  logic        pc_load,
  input  logic [15:0] pc_in,
  output logic [15:0] mem_address,
  output logic        mem_read,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic        ir_load,
  output logic [15:0] ir_data,
  output logic        fetch_done,
  output logic [15:0] instr_pc,
  output logic [15:0] pc_plus2
);

  lc3b_fetch_state state, next_state;
  lc3b_word        pc, pc_next, buffer, pending;
  logic            pc_ld, kill;
  lc3b_word        target;

  assign target = word_align(pc_in);

  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (pc_ld),
    .d       (pc_next),
    .q       (pc)
  );

  pc_register #(.RESET_PC(RESET_PC)) u_instr_pc (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (state == DELIVER),
    .d       (pc),
    .q       (instr_pc)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      buffer  <= '0;
      kill    <= 1'b0;
      pending <= '0;
    end else begin
      state <= next_state;
      if (state == REQ) begin
        // A redirect arriving with the response also kills that response.
        if (mem_resp) begin
          if (!(kill || pc_load)) buffer <= mem_rdata;
          kill <= 1'b0;
        end else if (pc_load) begin
          pending <= target;
          kill    <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    next_state = state;
    pc_ld      = 1'b0;
    pc_next    = pc_plus2;
    case (state)
      IDLE: begin
        if (pc_load) begin
          pc_ld   = 1'b1;
          pc_next = target;
        end
        if (fetch_req) next_state = REQ;
      end
      REQ: begin
        if (mem_resp) begin
          if (kill || pc_load) begin
            next_state = FLUSH;
            pc_ld      = 1'b1;
            pc_next    = pc_load ? target : pending;
          end else begin
            next_state = DELIVER;
          end
        end
      end
      FLUSH: begin
        next_state = REQ;
        if (pc_load) begin
          pc_ld   = 1'b1;
          pc_next = target;
        end
      end
      DELIVER: begin
        next_state = IDLE;
        pc_ld      = 1'b1;
        pc_next    = pc_load ? target : pc_plus2;
      end
      default: next_state = IDLE;
    endcase
  end

  assign mem_read    = (state == REQ);
  assign mem_address = pc;
  assign ir_load     = (state == DELIVER);
  assign fetch_done  = (state == DELIVER);
  assign ir_data     = buffer;
  assign pc_plus2    = pc + WORD_INC;

endmodule

`default_nettype wire
